// File: rtl/clk_div_pkg.sv
// Shared constants, config record and helpers for the clock-divider bank.
package clk_div_pkg;

  localparam int unsigned CFG_DIV_W    = 32;
  localparam int unsigned PKG_DEF_DIV0 = 12_500_000;
  localparam int unsigned PKG_DEF_DIVN = 2;
  localparam bit          PKG_DEF_CASC = 1'b1;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic                 casc;
  } cfg_t;

  // Channel-index width; a single channel still gets one address bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/config and output bundle of the clock-divider bank.
interface clk_div_bank_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 32
);
  localparam int unsigned CH_W = clk_div_pkg::ch_idx_w(N_CH);

  logic             en;
  logic             sync_clr;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_casc;
  logic [N_CH-1:0]  tick_o;
  logic [N_CH-1:0]  sq_o;
  logic             cfg_err;

  modport master (
    output en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_casc,
    input  tick_o, sq_o, cfg_err
  );

  modport slave (
    input  en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_casc,
    output tick_o, sq_o, cfg_err
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: config registers, counter, tick and square-wave outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned RST_DIV  = 2,
  parameter bit          RST_CASC = 1'b0,
  parameter bit          CAN_CASC = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic wr_i,
  input  cfg_t wr_cfg_i,
  input  logic up_tick_i,
  output logic tick_o,
  output logic sq_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             casc_q, casc_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             src_c;

  // A cascaded channel counts the registered tick of its upstream neighbour.
  assign src_c = en_i & (casc_q ? up_tick_i : 1'b1);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    casc_d = casc_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (wr_i) begin
      div_d  = DIV_W'(wr_cfg_i.div);
      casc_d = wr_cfg_i.casc & CAN_CASC;
    end
    if (clr_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (wr_i) begin
      cnt_d = '0;
    end else if (src_c) begin
      if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      div_q  <= DIV_W'(RST_DIV);
      casc_q <= RST_CASC & CAN_CASC;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      casc_q <= casc_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers with a cascade chain and a single-cycle config port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned DEF_DIV0 = PKG_DEF_DIV0,
  parameter int unsigned DEF_DIVN = PKG_DEF_DIVN,
  parameter bit          DEF_CASC = PKG_DEF_CASC
) (
  input logic           clk,
  input logic           rst,
  clk_div_bank_if.slave bus
);

  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic            ch_ok_c;
  logic            div_ok_c;
  logic            wr_ok_c;
  logic            err_q, err_d;
  cfg_t            wr_cfg_c;
  logic [N_CH-1:0] tick_w;
  logic [N_CH-1:0] sq_w;

  assign ch_ok_c  = 32'(bus.cfg_ch) < N_CH;
  assign div_ok_c = bus.cfg_div != '0;
  assign wr_ok_c  = bus.cfg_we & ch_ok_c & div_ok_c;
  assign wr_cfg_c = '{div: CFG_DIV_W'(bus.cfg_div), casc: bus.cfg_casc};

  always_comb begin
    err_d = 1'b0;
    if (bus.cfg_we && !(ch_ok_c && div_ok_c)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic up_tick;
    if (i == 0) begin : g_head
      assign up_tick = 1'b0;
    end else begin : g_link
      assign up_tick = tick_w[i-1];
    end

    clk_div_chan #(
      .DIV_W    (DIV_W),
      .RST_DIV  ((i == 0) ? DEF_DIV0 : DEF_DIVN),
      .RST_CASC ((i == 0) ? 1'b0 : DEF_CASC),
      .CAN_CASC (i != 0)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (bus.en),
      .clr_i     (bus.sync_clr),
      .wr_i      (wr_ok_c && (bus.cfg_ch == CH_W'(i))),
      .wr_cfg_i  (wr_cfg_c),
      .up_tick_i (up_tick),
      .tick_o    (tick_w[i]),
      .sq_o      (sq_w[i])
    );
  end

  assign bus.tick_o  = tick_w;
  assign bus.sq_o    = sq_w;
  assign bus.cfg_err = err_q;

endmodule
